conv_coef_loader: RTL and testbench
===================================

CONV_COEF_LOADER -- requirements
Module: conv_coef_loader

Interface
REQ-001 SHALL have parameter INPUT_CHANNELS, default 256; number of filter channels to load; legal range 1..256.
REQ-002 SHALL have parameter KERNEL_SIZE, default 2; taps per channel; legal range 1..256.
REQ-003 SHALL have port clk, input, 1 bit; clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1 bit; begins a full coefficient load when sampled high in IDLE.
REQ-006 SHALL have port abort, input, 1 bit; terminates a load in progress.
REQ-007 SHALL have port s_valid, input, 1 bit; coefficient stream beat valid.
REQ-008 SHALL have port s_data, input, 8 bits; signed coefficient value.
REQ-009 SHALL have port s_ready, output, 1 bit; loader accepts a beat.
REQ-010 SHALL have port h_write, output, 1 bit; write strobe to conv coefficient port.
REQ-011 SHALL have port h_index_channel, output, 8 bits; target channel of the write.
REQ-012 SHALL have port h_index_filter, output, 8 bits; target tap of the write.
REQ-013 SHALL have port h_value, output, 8 bits; coefficient written.
REQ-014 SHALL have port sample_en, output, 1 bit; conv datapath may advance samples.
REQ-015 SHALL have port busy, output, 1 bit; load sequence in progress.
REQ-016 SHALL have port done, output, 1 bit; one-cycle pulse on load completion.
REQ-017 SHALL have port err_start, output, 1 bit; one-cycle pulse when start is ignored.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, DONE; IDLE->LOAD on start; LOAD->DONE on acceptance of last beat; LOAD->IDLE on abort; DONE->IDLE unconditionally after one cycle.
REQ-019 SHALL drive s_ready = 1 only in LOAD, decoded from registered state; beat accepted when s_valid && s_ready.
REQ-020 SHALL present each accepted beat as h_write=1 exactly one cycle after acceptance, with h_value=s_data and the indices of that beat; h_write=0 otherwise.
REQ-021 SHALL order beats channel-major: tap 0..KERNEL_SIZE-1 for channel 0, then channel 1, ...; tap wraps to 0 and channel increments when tap==KERNEL_SIZE-1.
REQ-022 SHALL treat beat with channel==INPUT_CHANNELS-1 and tap==KERNEL_SIZE-1 as last; total beats per load = INPUT_CHANNELS*KERNEL_SIZE.
REQ-023 SHALL clear both index counters on IDLE->LOAD.
REQ-024 SHALL hold indices and counters unchanged on cycles with no acceptance (s_valid low = stall, no timeout).
REQ-025 SHALL assert done in DONE state only (same cycle as h_write of last beat), never on abort.
REQ-026 SHALL drive busy = 1 in LOAD and DONE, sample_en = 1 only in IDLE.
REQ-027 SHALL ignore start in LOAD or DONE and pulse err_start the following cycle; start and abort together in IDLE: start wins.
REQ-028 SHALL, on abort in LOAD, still write a beat accepted in that same cycle, then enter IDLE; already-written coefficients remain; no done.
REQ-029 SHALL ignore abort outside LOAD.
REQ-030 SHALL zero-extend counter values into 8-bit index ports.

Reset
REQ-031 SHALL, on reset, enter IDLE with counters 0, h_write=0, h_index_channel=0, h_index_filter=0, h_value=0, done=0, err_start=0, busy=0, s_ready=0, sample_en=1.
REQ-032 SHALL, on reset during LOAD, drop the load immediately with no h_write or done following deassertion.

Structure
REQ-033 SHALL place FSM state enum and index width constant (8) in shared package conv_ctrl_pkg.
REQ-034 SHALL implement tap/channel counting in one sub-module conv_coef_index_cnt (clear, advance, last flag).

Verification (INPUT_CHANNELS=4, KERNEL_SIZE=2)
REQ-035 SHALL verify full load: start, 8 back-to-back beats 0x01..0x08 -> h_write with (ch,tap)=(0,0)..(3,1), values 0x01..0x08, done pulse with last write, sample_en=1 next cycle.
REQ-036 SHALL verify stall: s_valid low 3 cycles after beat 2 -> no h_write during stall, indices resume at (1,0).
REQ-037 SHALL verify abort after beat 3 (same-cycle beat 0x0C) -> 0x0C written at (1,1), IDLE next cycle, no done, s_ready=0.
REQ-038 SHALL verify start during LOAD -> err_start pulse one cycle later, counters unaffected.
REQ-039 SHALL verify reset mid-load after beat 5 -> all outputs at reset values, sample_en=1, new start reloads from (0,0).
REQ-040 SHALL verify KERNEL_SIZE=1, INPUT_CHANNELS=1 -> single beat 0x7F written at (0,0) with done.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// ============================================================================
// conv_ctrl_pkg: shared FSM state encoding and index width for the conv loader
// Revision: 1.0
// ============================================================================
`default_nettype none

package conv_ctrl_pkg;

  localparam int IDX_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_t;

endpackage

`default_nettype wire

// File: rtl/conv_coef_index_cnt.sv
// ============================================================================
// conv_coef_index_cnt: channel-major tap/channel counter with last-beat flag
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_coef_index_cnt
  import conv_ctrl_pkg::*;
#(
  parameter int CHANNELS = 256,
  parameter int TAPS     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  output logic [IDX_W-1:0] channel,
  output logic [IDX_W-1:0] tap,
  output logic             last
);

  localparam logic [IDX_W-1:0] CH_MAX  = IDX_W'(CHANNELS - 1);
  localparam logic [IDX_W-1:0] TAP_MAX = IDX_W'(TAPS - 1);

  logic tap_wrap;

  assign tap_wrap = (tap == TAP_MAX);
  assign last     = tap_wrap && (channel == CH_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      channel <= '0;
      tap     <= '0;
    end else if (clear) begin
      channel <= '0;
      tap     <= '0;
    end else if (advance) begin
      if (tap_wrap) begin
        tap     <= '0;
        channel <= channel + 1'b1;
      end else begin
        tap <= tap + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/conv_coef_loader.sv
// ============================================================================
// conv_coef_loader: streams signed coefficients into the conv coefficient port
// Revision: 1.0
// ============================================================================
`default_nettype none

module conv_coef_loader
  import conv_ctrl_pkg::*;
#(
  parameter int INPUT_CHANNELS = 256,
  parameter int KERNEL_SIZE    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic             h_write,
  output logic [IDX_W-1:0] h_index_channel,
  output logic [IDX_W-1:0] h_index_filter,
  output logic [7:0]       h_value,
  output logic             sample_en,
  output logic             busy,
  output logic             done,
  output logic             err_start
);

  load_state_t      state;
  logic             accept;
  logic             cnt_clear;
  logic             cnt_last;
  logic [IDX_W-1:0] cnt_channel;
  logic [IDX_W-1:0] cnt_tap;

  assign s_ready   = (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);
  assign sample_en = (state == ST_IDLE);
  assign accept    = s_valid && s_ready;
  assign cnt_clear = (state == ST_IDLE) && start;

  conv_coef_index_cnt #(
    .CHANNELS (INPUT_CHANNELS),
    .TAPS     (KERNEL_SIZE)
  ) u_index_cnt (
    .clk     (clk),
    .reset   (reset),
    .clear   (cnt_clear),
    .advance (accept),
    .channel (cnt_channel),
    .tap     (cnt_tap),
    .last    (cnt_last)
  );

  // Abort beats a simultaneous last-beat acceptance: the beat is written but no done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      h_write         <= 1'b0;
      h_index_channel <= '0;
      h_index_filter  <= '0;
      h_value         <= '0;
      done            <= 1'b0;
      err_start       <= 1'b0;
    end else begin
      h_write   <= accept;
      done      <= 1'b0;
      err_start <= start && (state != ST_IDLE);
      if (accept) begin
        h_value         <= s_data;
        h_index_channel <= cnt_channel;
        h_index_filter  <= cnt_tap;
      end
      case (state)
        ST_IDLE: begin
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (accept && cnt_last) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_conv_coef_loader.sv
// ============================================================================
// tb_conv_coef_loader: directed checks for 4x2 and 1x1 coefficient loads
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_conv_coef_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, s_valid;
  logic [7:0] s_data;
  logic       s_ready, h_write, sample_en, busy, done, err_start;
  logic [7:0] h_ch, h_tap, h_value;

  logic       start1, abort1, s_valid1;
  logic [7:0] s_data1;
  logic       s_ready1, h_write1, sample_en1, busy1, done1, err_start1;
  logic [7:0] h_ch1, h_tap1, h_value1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conv_coef_loader #(.INPUT_CHANNELS(4), .KERNEL_SIZE(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .h_write(h_write), .h_index_channel(h_ch), .h_index_filter(h_tap),
    .h_value(h_value), .sample_en(sample_en), .busy(busy),
    .done(done), .err_start(err_start)
  );

  conv_coef_loader #(.INPUT_CHANNELS(1), .KERNEL_SIZE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .s_valid(s_valid1), .s_data(s_data1), .s_ready(s_ready1),
    .h_write(h_write1), .h_index_channel(h_ch1), .h_index_filter(h_tap1),
    .h_value(h_value1), .sample_en(sample_en1), .busy(busy1),
    .done(done1), .err_start(err_start1)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".h_write"}, {7'd0, h_write}, 8'd0);
    chk({tag, ".done"}, {7'd0, done}, 8'd0);
    chk({tag, ".busy"}, {7'd0, busy}, 8'd0);
    chk({tag, ".s_ready"}, {7'd0, s_ready}, 8'd0);
    chk({tag, ".sample_en"}, {7'd0, sample_en}, 8'd1);
  endtask

  // Drive one beat for one cycle and check the write that appears right after the edge.
  task automatic beat(input string tag, input logic [7:0] d, input logic [7:0] ch,
                      input logic [7:0] tp, input logic dn);
    s_valid = 1'b1;
    s_data  = d;
    step();
    s_valid = 1'b0;
    chk({tag, ".h_write"}, {7'd0, h_write}, 8'd1);
    chk({tag, ".h_value"}, h_value, d);
    chk({tag, ".ch"}, h_ch, ch);
    chk({tag, ".tap"}, h_tap, tp);
    chk({tag, ".done"}, {7'd0, done}, {7'd0, dn});
  endtask

  task automatic begin_load();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 0; abort = 0; s_valid = 0; s_data = 0;
    start1 = 0; abort1 = 0; s_valid1 = 0; s_data1 = 0;
    step(); step();
    chk_idle_outputs("rst");
    chk("rst.ch", h_ch, 8'd0);
    chk("rst.tap", h_tap, 8'd0);
    chk("rst.val", h_value, 8'd0);
    chk("rst.err", {7'd0, err_start}, 8'd0);
    reset = 1'b0;
    step();

    // Full back-to-back load
    begin_load();
    chk("full.s_ready", {7'd0, s_ready}, 8'd1);
    chk("full.busy", {7'd0, busy}, 8'd1);
    chk("full.sample_en", {7'd0, sample_en}, 8'd0);
    for (int i = 0; i < 8; i++)
      beat("full", 8'(i + 1), 8'(i / 2), 8'(i % 2), (i == 7));
    chk("full.busy_done", {7'd0, busy}, 8'd1);
    step();
    chk_idle_outputs("full.after");

    // Stall after beat 2
    begin_load();
    beat("stall.b0", 8'h21, 8'd0, 8'd0, 1'b0);
    beat("stall.b1", 8'h22, 8'd0, 8'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall.no_write", {7'd0, h_write}, 8'd0);
    end
    beat("stall.b2", 8'h23, 8'd1, 8'd0, 1'b0);
    for (int i = 3; i < 8; i++)
      beat("stall.rest", 8'(8'h20 + i + 1), 8'(i / 2), 8'(i % 2), (i == 7));
    step();

    // Abort with a same-cycle beat; start and abort together in IDLE, start wins
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort.start_wins", {7'd0, busy}, 8'd1);
    beat("abort.b0", 8'h0A, 8'd0, 8'd0, 1'b0);
    beat("abort.b1", 8'h0B, 8'd0, 8'd1, 1'b0);
    beat("abort.b2", 8'h0D, 8'd1, 8'd0, 1'b0);
    abort = 1'b1;
    beat("abort.b3", 8'h0C, 8'd1, 8'd1, 1'b0);
    abort = 1'b0;
    chk("abort.s_ready", {7'd0, s_ready}, 8'd0);
    chk("abort.sample_en", {7'd0, sample_en}, 8'd1);
    step();
    chk_idle_outputs("abort.after");

    // Start while loading
    begin_load();
    beat("errs.b0", 8'h31, 8'd0, 8'd0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("errs.pulse", {7'd0, err_start}, 8'd1);
    step();
    chk("errs.clear", {7'd0, err_start}, 8'd0);
    beat("errs.b1", 8'h32, 8'd0, 8'd1, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("errs.aborted", {7'd0, busy}, 8'd0);

    // Reset in the middle of a load
    begin_load();
    for (int i = 0; i < 5; i++)
      beat("rml", 8'(8'h40 + i), 8'(i / 2), 8'(i % 2), 1'b0);
    reset = 1'b1;
    #1;
    chk_idle_outputs("rml.rst");
    chk("rml.ch", h_ch, 8'd0);
    chk("rml.tap", h_tap, 8'd0);
    chk("rml.val", h_value, 8'd0);
    step();
    reset = 1'b0;
    s_valid = 1'b1; s_data = 8'h99;
    step();
    s_valid = 1'b0;
    chk("rml.idle_no_write", {7'd0, h_write}, 8'd0);
    chk("rml.idle_no_done", {7'd0, done}, 8'd0);
    begin_load();
    beat("rml.reload", 8'h55, 8'd0, 8'd0, 1'b0);
    abort = 1'b1;
    step();
    abort = 1'b0;

    // Single-channel single-tap instance
    chk("one.sample_en", {7'd0, sample_en1}, 8'd1);
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    s_valid1 = 1'b1; s_data1 = 8'h7F;
    step();
    s_valid1 = 1'b0;
    chk("one.h_write", {7'd0, h_write1}, 8'd1);
    chk("one.val", h_value1, 8'h7F);
    chk("one.ch", h_ch1, 8'd0);
    chk("one.tap", h_tap1, 8'd0);
    chk("one.done", {7'd0, done1}, 8'd1);
    step();
    chk("one.after_done", {7'd0, done1}, 8'd0);
    chk("one.after_sample_en", {7'd0, sample_en1}, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
